// File: rtl/slave_in_port_burst.sv
// Serial slave receive port: LSB-first address/burst header, optional write data beats,
// one {write, address, data} entry per beat pushed into a first-word-fall-through FIFO.
module slave_in_port_burst #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned BURST_WIDTH = 4,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_address,
  input  logic                          rx_burst,
  input  logic                          rx_data,
  input  logic                          master_valid,
  input  logic                          write_en,
  input  logic                          read_en,
  output logic                          slave_ready,
  output logic                          rx_done,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_write,
  output logic [ADDR_WIDTH-1:0]         out_addr,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned AcntW  = $clog2(ADDR_WIDTH + 1);
  localparam int unsigned DcntW  = $clog2(DATA_WIDTH + 1);
  localparam int unsigned EntryW = 1 + ADDR_WIDTH + DATA_WIDTH;

  localparam logic [PtrW:0]    CntFull  = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [PtrW:0]    CntOne   = (PtrW + 1)'(1);
  localparam logic [PtrW-1:0]  PtrOne   = PtrW'(1);
  localparam logic [AcntW-1:0] AcntLast = AcntW'(ADDR_WIDTH - 1);
  localparam logic [AcntW-1:0] AcntBurst = AcntW'(BURST_WIDTH);
  localparam logic [DcntW-1:0] DcntLast = DcntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StHdr, StData} state_e;

  state_e                  state_q, state_d;
  logic                    op_write_q, op_write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d, addr_shift;
  logic [BURST_WIDTH-1:0]  len_q, len_d, len_shift;
  logic [BURST_WIDTH-1:0]  beat_q, beat_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d, data_shift;
  logic [AcntW-1:0]        acnt_q, acnt_d;
  logic [DcntW-1:0]        dcnt_q, dcnt_d;
  logic                    done_q, done_d;
  logic                    push, pop, accept;
  logic [EntryW-1:0]       push_entry;

  logic [EntryW-1:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]           count_q, count_d;

  // New bits enter at the MSB so that after a full field the first bit sits at bit 0.
  assign addr_shift = {rx_address, addr_q[ADDR_WIDTH-1:1]};
  assign len_shift  = BURST_WIDTH'({rx_burst, len_q} >> 1);
  assign data_shift = DATA_WIDTH'({rx_data, data_q} >> 1);

  assign slave_ready = (count_q != CntFull);
  assign accept      = master_valid && slave_ready;
  assign out_valid   = (count_q != '0);
  assign pop         = out_valid && out_ready;
  assign fifo_count  = count_q;
  assign rx_done     = done_q;
  assign {out_write, out_addr, out_data} = out_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    state_d    = state_q;
    op_write_d = op_write_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    data_d     = data_q;
    acnt_d     = acnt_q;
    dcnt_d     = dcnt_q;
    done_d     = 1'b0;
    push       = 1'b0;
    push_entry = '0;
    unique case (state_q)
      StIdle: begin
        if (accept && (write_en ^ read_en)) begin
          op_write_d = write_en;
          addr_d     = addr_shift;
          len_d      = len_shift;
          acnt_d     = AcntW'(1);
          state_d    = StHdr;
        end
      end
      StHdr: begin
        if (accept) begin
          addr_d = addr_shift;
          if (acnt_q < AcntBurst) len_d = len_shift;
          if (acnt_q == AcntLast) begin
            if (op_write_q) begin
              beat_d  = '0;
              dcnt_d  = '0;
              state_d = StData;
            end else begin
              push       = 1'b1;
              push_entry = {1'b0, addr_shift, {DATA_WIDTH{1'b0}}};
              done_d     = 1'b1;
              state_d    = StIdle;
            end
          end else begin
            acnt_d = acnt_q + AcntW'(1);
          end
        end
      end
      StData: begin
        if (accept) begin
          data_d = data_shift;
          if (dcnt_q == DcntLast) begin
            push       = 1'b1;
            push_entry = {1'b1, addr_q + ADDR_WIDTH'(beat_q), data_shift};
            dcnt_d     = '0;
            if (beat_q == len_q) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              beat_d = beat_q + BURST_WIDTH'(1);
            end
          end else begin
            dcnt_d = dcnt_q + DcntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntOne;
    end else if (!push && pop) begin
      count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      data_q     <= '0;
      acnt_q     <= '0;
      dcnt_q     <= '0;
      done_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      data_q     <= data_d;
      acnt_q     <= acnt_d;
      dcnt_q     <= dcnt_d;
      done_q     <= done_d;
      count_q    <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

endmodule

// File: tb/tb_slave_in_port_burst.sv
// Bench for slave_in_port_burst: bit-index transaction model compared every cycle,
// plus literal expectations on the entries each directed scenario must deliver.
module tb_slave_in_port_burst;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int BW = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_address = 1'b0, rx_burst = 1'b0, rx_data = 1'b0;
  logic master_valid = 1'b0, write_en = 1'b0, read_en = 1'b0, out_ready = 1'b1;
  logic slave_ready, rx_done, out_valid, out_write;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic [2:0] fifo_count;

  int checks = 0;
  int errors = 0;

  slave_in_port_burst dut (
    .clk(clk), .reset(reset), .rx_address(rx_address), .rx_burst(rx_burst),
    .rx_data(rx_data), .master_valid(master_valid), .write_en(write_en), .read_en(read_en),
    .slave_ready(slave_ready), .rx_done(rx_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_write(out_write), .out_addr(out_addr), .out_data(out_data), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- model: transaction decoded from the accepted-bit index ----------------
  logic [20:0] exp_q[$];
  logic        exp_done = 1'b0;
  bit          m_active = 0, m_wr = 0;
  int          m_idx = 0;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_len;
  logic [DW-1:0] m_data;

  task automatic model_step();
    bit ready;
    int k, beat, pos;
    if (reset) begin
      exp_q.delete();
      exp_done = 1'b0;
      m_active = 0;
      return;
    end
    exp_done = 1'b0;
    ready = (exp_q.size() != DEPTH);
    if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
    if (master_valid && ready) begin
      if (!m_active && (write_en ^ read_en)) begin
        m_active = 1; m_wr = write_en; m_idx = 0;
        m_addr = '0; m_len = '0; m_data = '0;
      end
      if (m_active) begin
        if (m_idx < AW) begin
          m_addr[m_idx] = rx_address;
          if (m_idx < BW) m_len[m_idx] = rx_burst;
          if (m_idx == AW - 1 && !m_wr) begin
            exp_q.push_back({1'b0, m_addr, 8'h00});
            exp_done = 1'b1;
            m_active = 0;
          end
        end else begin
          k = m_idx - AW;
          beat = k / DW;
          pos = k % DW;
          m_data[pos] = rx_data;
          if (pos == DW - 1) begin
            exp_q.push_back({1'b1, AW'(int'(m_addr) + beat), m_data});
            m_data = '0;
            if (beat == int'(m_len)) begin
              exp_done = 1'b1;
              m_active = 0;
            end
          end
        end
        m_idx++;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  logic [20:0] seen[$];
  int done_cnt = 0;

  initial forever begin
    @(negedge clk);
    check("slave_ready", 32'(slave_ready), 32'(exp_q.size() != DEPTH));
    check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
    check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    check("rx_done", 32'(rx_done), 32'(exp_done));
    if (exp_q.size() != 0) check("head", 32'({out_write, out_addr, out_data}), 32'(exp_q[0]));
    if (out_valid && out_ready) seen.push_back({out_write, out_addr, out_data});
    if (rx_done) done_cnt++;
  end

  // ---------------- stimulus (inputs change at posedge+2) ----------------
  task automatic idle(input int n);
    master_valid = 1'b0;
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send_bit(input logic a, input logic b, input logic d, input logic we,
                          input logic re);
    bit rdy;
    master_valid = 1'b1; rx_address = a; rx_burst = b; rx_data = d;
    write_en = we; read_en = re;
    for (int n = 0; ; n++) begin
      rdy = slave_ready;
      @(posedge clk); #2;
      if (rdy) break;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL accept_timeout actual=stalled required=accepted at %0t", $time);
        break;
      end
    end
    master_valid = 1'b0;
  endtask

  // Header op lines toggle after the first bit; the DUT must ignore them.
  task automatic header(input logic [AW-1:0] a, input logic [BW-1:0] len, input bit wr,
                        input bit stall);
    for (int i = 0; i < AW; i++) begin
      send_bit(a[i], (i < BW) ? len[i] : 1'b1, 1'b1,
               (i == 0) ? wr : i[0], (i == 0) ? !wr : !i[0]);
      if (stall && i == 5) idle(5);
    end
  endtask

  task automatic write_txn(input logic [AW-1:0] a, input logic [BW-1:0] len,
                           input logic [DW-1:0] d [16], input bit stall);
    header(a, len, 1'b1, stall);
    for (int b = 0; b <= int'(len); b++) begin
      for (int j = 0; j < DW; j++) begin
        send_bit(1'b0, 1'b1, d[b][j], 1'b0, 1'b1);
        if (stall && b == 1 && j == 3) idle(5);
      end
    end
    master_valid = 1'b0;
  endtask

  task automatic expect_seen(input string name, input logic [20:0] e [8], input int n,
                             input int dones);
    check({name, "_entries"}, 32'(seen.size()), 32'(n));
    for (int i = 0; i < n; i++)
      if (i < seen.size()) check({name, "_entry"}, 32'(seen[i]), 32'(e[i]));
    check({name, "_rx_done"}, 32'(done_cnt), 32'(dones));
    check({name, "_drained"}, 32'(fifo_count), 32'(0));
    seen.delete();
    done_cnt = 0;
  endtask

  task automatic check_reset_values();
    check("rst_slave_ready", 32'(slave_ready), 32'(1));
    check("rst_rx_done", 32'(rx_done), 32'(0));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_write", 32'(out_write), 32'(0));
    check("rst_out_addr", 32'(out_addr), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_fifo_count", 32'(fifo_count), 32'(0));
  endtask

  logic [7:0]  dv [16];
  logic [20:0] ev [8];

  initial begin
    foreach (dv[i]) dv[i] = 8'h00;
    foreach (ev[i]) ev[i] = 21'h0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_values();
    reset = 1'b0;
    idle(2);

    // Single write
    dv[0] = 8'hBD;
    write_txn(12'hADD, 4'd0, dv, 0);
    idle(6);
    ev[0] = {1'b1, 12'hADD, 8'hBD};
    expect_seen("single", ev, 1, 1);

    // Burst with address wrap
    dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'h33; dv[3] = 8'h44;
    write_txn(12'hFFE, 4'd3, dv, 0);
    idle(6);
    ev[0] = {1'b1, 12'hFFE, 8'h11}; ev[1] = {1'b1, 12'hFFF, 8'h22};
    ev[2] = {1'b1, 12'h000, 8'h33}; ev[3] = {1'b1, 12'h001, 8'h44};
    expect_seen("burst_wrap", ev, 4, 1);

    // Read
    header(12'h123, 4'd7, 1'b0, 0);
    idle(6);
    ev[0] = {1'b0, 12'h123, 8'h00};
    expect_seen("read", ev, 1, 1);

    // Backpressure: FIFO fills after four beats, then drains
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) dv[i] = 8'(i + 1);
    fork
      write_txn(12'h040, 4'd5, dv, 0);
      begin
        repeat (60) @(posedge clk);
        #2;
        check("bp_full_count", 32'(fifo_count), 32'(4));
        check("bp_not_ready", 32'(slave_ready), 32'(0));
        out_ready = 1'b1;
      end
    join
    idle(8);
    for (int i = 0; i < 6; i++) ev[i] = {1'b1, 12'(12'h040 + i), 8'(i + 1)};
    expect_seen("backpressure", ev, 6, 1);

    // Stalls mid-address and mid-beat
    dv[0] = 8'hA1; dv[1] = 8'hB2;
    write_txn(12'h5A5, 4'd1, dv, 1);
    idle(6);
    ev[0] = {1'b1, 12'h5A5, 8'hA1}; ev[1] = {1'b1, 12'h5A6, 8'hB2};
    expect_seen("stall", ev, 2, 1);

    // Reset during a data phase with entries queued
    out_ready = 1'b0;
    dv[0] = 8'h01; dv[1] = 8'h02;
    write_txn(12'h300, 4'd1, dv, 0);
    header(12'h700, 4'd2, 1'b1, 0);
    for (int j = 0; j < 3; j++) send_bit(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    check_reset_values();
    @(posedge clk); #2;
    reset = 1'b0;
    out_ready = 1'b1;
    idle(2);
    seen.delete();
    done_cnt = 0;
    dv[0] = 8'h3C;
    write_txn(12'h0F0, 4'd0, dv, 0);
    idle(6);
    ev[0] = {1'b1, 12'h0F0, 8'h3C};
    expect_seen("after_reset", ev, 1, 1);

    // write_en == read_en: nothing received
    for (int i = 0; i < AW + DW; i++) send_bit(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    idle(6);
    expect_seen("both_en", ev, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
